lane_move_scheduler: RTL and testbench

//   Sequences the per-lane obstacle followers of the VGA crossy-road game.
//   - Divides the frame tick into per-lane move pulses at lane-specific speeds, scaled by level.
//   - Grants at most one lane move per clock, in round-robin order.
//   - Drives each follower's reset (load start position) on game start/restart.
//   - Sits between the frame timing logic and the NUM_LANES horizontal followers.

---
 rtl/lane_move_scheduler.sv | 141 ++++++++++++++
 tb/tb_lane_move_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lane_move_scheduler.sv
// Lane move scheduler: divides the frame tick into per-lane move strobes at level-scaled
// periods and issues at most one lane move per clock in round-robin order.
module lane_move_scheduler #(
   parameter int unsigned                   NUM_LANES  = 4,
   parameter int unsigned                   CNT_W      = 4,
   parameter logic [NUM_LANES*CNT_W-1:0]    PERIODS    = 16'h6432,
   parameter int unsigned                   MIN_PERIOD = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 pause,
   input  logic                 frame_tick,
   input  logic [2:0]           level,
   output logic [NUM_LANES-1:0] move,
   output logic [NUM_LANES-1:0] lane_reset,
   output logic                 running,
   output logic                 overrun
);

   localparam int unsigned PtrW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {StIdle, StInit, StRun, StPause} state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q [NUM_LANES];
   logic [NUM_LANES-1:0] pending_q;
   logic [PtrW-1:0]      rr_ptr_q;
   logic [NUM_LANES-1:0] move_q;
   logic [NUM_LANES-1:0] lane_reset_q;
   logic                 running_q;
   logic                 overrun_q;

   logic [CNT_W:0]       lvl_x;
   logic [CNT_W:0]       min_x;
   logic [CNT_W:0]       eff [NUM_LANES];
   logic [NUM_LANES-1:0] expire;
   logic [NUM_LANES-1:0] tick_set;

   assign lvl_x = (CNT_W+1)'(level);
   assign min_x = (CNT_W+1)'(MIN_PERIOD);

   // One extra bit keeps period - level from wrapping before the floor is applied.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [CNT_W:0] per_x;
      assign per_x     = {1'b0, PERIODS[g*CNT_W +: CNT_W]};
      assign eff[g]    = (per_x >= lvl_x + min_x) ? (per_x - lvl_x) : min_x;
      assign expire[g] = ({1'b0, cnt_q[g]} + (CNT_W+1)'(1)) >= eff[g];
   end

   assign tick_set = frame_tick ? expire : '0;

   logic                 found;
   logic [PtrW-1:0]      sel;
   int unsigned          idx;
   logic [NUM_LANES-1:0] sel_onehot;
   logic [PtrW-1:0]      rr_next;

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_LANES;
         if (!found && pending_q[idx]) begin
            found = 1'b1;
            sel   = PtrW'(idx);
         end
      end
      sel_onehot = found ? (NUM_LANES'(1) << sel) : '0;
      rr_next    = found ? PtrW'((int'(sel) + 1) % NUM_LANES) : rr_ptr_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
         pending_q    <= '0;
         rr_ptr_q     <= '0;
         move_q       <= '0;
         lane_reset_q <= '1;
         running_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         move_q <= '0;
         case (state_q)
            StIdle: begin
               lane_reset_q <= '1;
               running_q    <= 1'b0;
               if (start) state_q <= StInit;
            end
            StInit: begin
               for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
               pending_q    <= '0;
               overrun_q    <= 1'b0;
               rr_ptr_q     <= '0;
               lane_reset_q <= '0;
               running_q    <= 1'b1;
               state_q      <= StRun;
            end
            StRun: begin
               if (start) begin
                  state_q      <= StInit;
                  lane_reset_q <= '1;
                  running_q    <= 1'b0;
               end else if (pause) begin
                  state_q   <= StPause;
                  running_q <= 1'b0;
               end else begin
                  if (frame_tick) begin
                     for (int i = 0; i < NUM_LANES; i++) begin
                        cnt_q[i] <= expire[i] ? '0 : cnt_q[i] + CNT_W'(1);
                     end
                  end
                  // A fresh expiry wins over the issue clear of the same lane.
                  pending_q <= (pending_q & ~sel_onehot) | tick_set;
                  if (|(tick_set & pending_q & ~sel_onehot)) overrun_q <= 1'b1;
                  move_q    <= sel_onehot;
                  rr_ptr_q  <= rr_next;
               end
            end
            StPause: begin
               if (start) begin
                  state_q      <= StInit;
                  lane_reset_q <= '1;
               end else if (!pause) begin
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign move       = move_q;
   assign lane_reset = lane_reset_q;
   assign running    = running_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_lane_move_scheduler.sv
// Scoreboard bench for lane_move_scheduler: expected lane moves are queued with the stimulus
// and a negedge monitor pops and compares each strobe.
module tb_lane_move_scheduler;

   logic       clk = 1'b0;
   logic       reset, start, pause, frame_tick;
   logic [2:0] level;
   logic [3:0] move, lane_reset;
   logic       running, overrun;

   int total = 0;
   int bad   = 0;
   int exp_q [$];
   int lane;

   // Expected issue order per tick for level 0 from a fresh start (hand-derived).
   int exp2 [12][4] = '{
      '{-1, -1, -1, -1}, '{ 0, -1, -1, -1}, '{ 1, -1, -1, -1}, '{ 2,  0, -1, -1},
      '{-1, -1, -1, -1}, '{ 1,  3,  0, -1}, '{-1, -1, -1, -1}, '{ 2,  0, -1, -1},
      '{ 1, -1, -1, -1}, '{ 0, -1, -1, -1}, '{-1, -1, -1, -1}, '{ 1,  2,  3,  0}};

   lane_move_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .frame_tick (frame_tick),
      .level      (level),
      .move       (move),
      .lane_reset (lane_reset),
      .running    (running),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && move !== 4'b0) begin
         check("move_onehot", $countones(move), 1);
         check("move_running", running, 1);
         if (exp_q.size() == 0) begin
            check("move_unexpected", move, 0);
         end else begin
            lane = exp_q.pop_front();
            check("move_lane", move, 4'b1 << lane);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int l);
      exp_q.push_back(l);
   endtask

   task automatic tick(input int gap);
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(gap);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      @(negedge clk);
      check("init_lane_reset", lane_reset, 4'hF);
      check("init_running", running, 0);
      cyc(1);
      @(negedge clk);
      check("run_lane_reset", lane_reset, 4'h0);
      check("run_running", running, 1);
      check("run_move", move, 0);
      check("run_overrun", overrun, 0);
      cyc(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; frame_tick = 1'b0; level = 3'd0;
      cyc(3);
      @(negedge clk);
      check("rst_lane_reset", lane_reset, 4'hF);
      check("rst_move", move, 0);
      check("rst_running", running, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b0;
      tick(4);
      tick(4);
      check("idle_running", running, 0);

      // Level 0: base periods 2,3,4,6 over 12 ticks.
      do_start();
      for (int t = 0; t < 12; t++) begin
         for (int j = 0; j < 4; j++) if (exp2[t][j] >= 0) push(exp2[t][j]);
         tick(8);
      end
      drain("lvl0_drain");
      check("lvl0_overrun", overrun, 0);

      // Level 3: lanes 0-2 clamp to 1, lane 3 becomes 3.
      level = 3'd3;
      do_start();
      push(0); push(1); push(2); tick(8);
      push(0); push(1); push(2); tick(8);
      push(3); push(0); push(1); push(2); tick(8);
      drain("lvl3_drain");

      // Level 5: every lane clamps to 1; check issue latency cycle by cycle.
      level = 3'd5;
      do_start();
      push(0); push(1); push(2); push(3);
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      @(negedge clk);
      check("lat_first_edge", move, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         @(negedge clk);
         check("lat_seq", move, 4'b1 << i);
      end
      cyc(1);
      @(negedge clk);
      check("lat_done", move, 0);
      cyc(4);
      push(0); push(1); push(2); push(3); tick(8);
      drain("lvl5_drain");
      check("lvl5_overrun", overrun, 0);

      // Pause with lanes 2 and 0 pending; ticks while paused are ignored.
      level = 3'd0;
      do_start();
      tick(8);
      push(0); tick(8);
      push(1); tick(8);
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      pause = 1'b1;
      cyc(1);
      @(negedge clk);
      check("pause_running", running, 0);
      check("pause_move", move, 0);
      cyc(1);
      for (int i = 0; i < 5; i++) tick(4);
      push(2); push(0);
      pause = 1'b0;
      cyc(2);
      @(negedge clk);
      check("pause_release", move, 4'b0100);
      cyc(4);
      tick(8);
      push(1); push(3); push(0); tick(8);
      drain("pause_drain");
      check("pause_overrun", overrun, 0);

      // Adjacent ticks at level 5 re-expire pending lanes.
      level = 3'd5;
      do_start();
      push(0); push(1); push(2); push(3); push(0);
      frame_tick = 1'b1;
      cyc(2);
      frame_tick = 1'b0;
      cyc(8);
      drain("ovr_drain");
      check("ovr_set", overrun, 1);
      push(1); push(2); push(3); push(0); tick(8);
      drain("ovr_drain2");
      check("ovr_sticky", overrun, 1);
      do_start();
      check("ovr_cleared", overrun, 0);

      // Start mid-RUN while lanes 0,1,3 are pending: they are discarded.
      level = 3'd0;
      tick(8);
      push(0); tick(8);
      push(1); tick(8);
      push(2); push(0); tick(8);
      tick(8);
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      @(negedge clk);
      check("restart_lane_reset", lane_reset, 4'hF);
      check("restart_move", move, 0);
      check("restart_running", running, 0);
      cyc(1);
      @(negedge clk);
      check("restart_run_lane_reset", lane_reset, 4'h0);
      check("restart_run_running", running, 1);
      cyc(6);
      tick(8);
      push(0); tick(8);
      drain("restart_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
